// File: rtl/present_pkg.sv
// Shared PRESENT-80 definitions: widths, round count, S-box, bit permutation
// and the encryption phase encoding used by the core's control FSM.
package present_pkg;

   localparam int BLOCK_W = 64;
   localparam int KEY_W   = 80;
   localparam int ROUNDS  = 31;

   localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_ROUND,
      PH_FINAL
   } phase_t;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hC;
         4'h1: y = 4'h5;
         4'h2: y = 4'h6;
         4'h3: y = 4'hB;
         4'h4: y = 4'h9;
         4'h5: y = 4'h0;
         4'h6: y = 4'hA;
         4'h7: y = 4'hD;
         4'h8: y = 4'h3;
         4'h9: y = 4'hE;
         4'hA: y = 4'hF;
         4'hB: y = 4'h8;
         4'hC: y = 4'h4;
         4'hD: y = 4'h7;
         4'hE: y = 4'h1;
         default: y = 4'h2;
      endcase
      return y;
   endfunction

   // Bit j moves to (16*j) mod 63; bit 63 is a fixed point of the permutation.
   function automatic logic [BLOCK_W-1:0] p_layer(input logic [BLOCK_W-1:0] s);
      logic [BLOCK_W-1:0] r;
      r = '0;
      for (int j = 0; j < BLOCK_W - 1; j++) begin
         r[(16 * j) % 63] = s[j];
      end
      r[BLOCK_W-1] = s[BLOCK_W-1];
      return r;
   endfunction

endpackage

// File: rtl/present_sbox.sv
// Single 4-bit PRESENT S-box, purely combinational.
module present_sbox
   import present_pkg::*;
(
   input  logic [3:0] din,
   output logic [3:0] dout
);

   assign dout = sbox(din);

endmodule

// File: rtl/present_encrypt_core.sv
// Iterative PRESENT-80 encryption core: one round per clock, 32 cycles from
// load to done, with the final key whitening applied on the last edge.
module present_encrypt_core
   import present_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [BLOCK_W-1:0] idat,
   input  logic [KEY_W-1:0]   key,
   output logic [BLOCK_W-1:0] odat,
   output logic               done
);

   phase_t             phase_reg, phase_next;
   logic [BLOCK_W-1:0] state_reg, state_next;
   logic [KEY_W-1:0]   key_reg, key_next;
   logic [4:0]         round_reg, round_next;
   logic [BLOCK_W-1:0] odat_reg, odat_next;
   logic               done_reg, done_next;

   logic [BLOCK_W-1:0] round_in;
   logic [BLOCK_W-1:0] sbox_out;
   logic [KEY_W-1:0]   key_rot;
   logic [3:0]         key_sbox_out;
   logic [KEY_W-1:0]   key_upd;

   assign round_in = state_reg ^ key_reg[KEY_W-1:16];

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_state_sbox
         present_sbox u_sbox (
            .din  (round_in[4*gi +: 4]),
            .dout (sbox_out[4*gi +: 4])
         );
      end
   endgenerate

   // Rotate left by 61 is the same as rotate right by 19.
   assign key_rot = {key_reg[18:0], key_reg[KEY_W-1:19]};

   present_sbox u_key_sbox (
      .din  (key_rot[79:76]),
      .dout (key_sbox_out)
   );

   assign key_upd = {key_sbox_out, key_rot[75:20], key_rot[19:15] ^ round_reg, key_rot[14:0]};

   always_comb begin
      phase_next = phase_reg;
      state_next = state_reg;
      key_next   = key_reg;
      round_next = round_reg;
      odat_next  = odat_reg;
      done_next  = done_reg;
      if (load) begin
         // A new load wins over any in-flight work, including the final edge.
         phase_next = PH_ROUND;
         state_next = idat;
         key_next   = key;
         round_next = 5'd1;
         done_next  = 1'b0;
      end else begin
         case (phase_reg)
            PH_ROUND: begin
               state_next = p_layer(sbox_out);
               key_next   = key_upd;
               if (round_reg == LAST_ROUND) begin
                  phase_next = PH_FINAL;
               end else begin
                  round_next = round_reg + 5'd1;
               end
            end
            PH_FINAL: begin
               odat_next  = round_in;
               done_next  = 1'b1;
               phase_next = PH_IDLE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_reg <= PH_IDLE;
         state_reg <= '0;
         key_reg   <= '0;
         round_reg <= '0;
         odat_reg  <= '0;
         done_reg  <= 1'b0;
      end else begin
         phase_reg <= phase_next;
         state_reg <= state_next;
         key_reg   <= key_next;
         round_reg <= round_next;
         odat_reg  <= odat_next;
         done_reg  <= done_next;
      end
   end

   assign odat = odat_reg;
   assign done = done_reg;

endmodule

// File: tb/tb_present_encrypt_core.sv
// Self-checking bench for present_encrypt_core: known-answer vectors, latency,
// hold, abort/reload, reset behaviour and back-to-back random traffic.
module tb_present_encrypt_core;

   logic        clk = 1'b0;
   logic        reset;
   logic        load;
   logic [63:0] idat;
   logic [79:0] key;
   logic [63:0] odat;
   logic        done;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [63:0] exp_q[$];
   logic [63:0] last_result;

   present_encrypt_core dut (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .idat  (idat),
      .key   (key),
      .odat  (odat),
      .done  (done)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] ref_sbox(input logic [3:0] x);
      case (x)
         4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
         4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
         4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
         4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
      endcase
   endfunction

   function automatic logic [63:0] ref_encrypt(input logic [63:0] p, input logic [79:0] k);
      logic [63:0] s, t;
      logic [79:0] kr;
      s  = p;
      kr = k;
      for (int r = 1; r <= 31; r++) begin
         s = s ^ kr[79:16];
         for (int n = 0; n < 16; n++) s[4*n +: 4] = ref_sbox(s[4*n +: 4]);
         t = '0;
         for (int j = 0; j < 64; j++) t[(j == 63) ? 63 : (j * 16) % 63] = s[j];
         s  = t;
         kr = {kr[18:0], kr[79:19]};
         kr[79:76] = ref_sbox(kr[79:76]);
         kr[19:15] = kr[19:15] ^ 5'(r);
      end
      return s ^ kr[79:16];
   endfunction

   function automatic logic [63:0] rand64();
      return {$urandom, $urandom};
   endfunction

   function automatic logic [79:0] rand80();
      return {16'($urandom), $urandom, $urandom};
   endfunction

   // Load edge sits between the two negedges; returns at the negedge after it.
   task automatic drive_load(input logic [63:0] p, input logic [79:0] k, input logic [63:0] e);
      @(negedge clk);
      idat = p;
      key  = k;
      load = 1'b1;
      exp_q.delete();
      exp_q.push_back(e);
      @(negedge clk);
      load = 1'b0;
   endtask

   // Counts edges after the load edge until done is seen (bounded at 40).
   task automatic wait_done(output int lat);
      lat = 0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      load  = 1'b0;
      idat  = rand64();
      key   = rand80();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      tests_run++;
      if (odat !== 64'h0) begin
         tests_failed++;
         $display("FAIL reset_odat: got %h expected %h", odat, 64'h0);
      end
      tests_run++;
      if (done !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_done: got %b expected 0", done);
      end
   endtask

   task automatic test_known_vectors();
      logic [63:0] pv [4];
      logic [79:0] kv [4];
      logic [63:0] cv [4];
      logic [63:0] e;
      int lat;
      pv[0] = 64'h0;                kv[0] = 80'h0;                    cv[0] = 64'h5579C1387B228445;
      pv[1] = 64'hFFFFFFFFFFFFFFFF; kv[1] = 80'h0;                    cv[1] = 64'hA112FFC72F68417B;
      pv[2] = 64'h0;                kv[2] = 80'hFFFFFFFFFFFFFFFFFFFF; cv[2] = 64'hE72C46C0F5945049;
      pv[3] = 64'hFFFFFFFFFFFFFFFF; kv[3] = 80'hFFFFFFFFFFFFFFFFFFFF; cv[3] = 64'h3333DCD3213210D2;
      for (int i = 0; i < 4; i++) begin
         drive_load(pv[i], kv[i], cv[i]);
         if (i > 0) begin
            tests_run++;
            if (done !== 1'b0 || odat !== last_result) begin
               tests_failed++;
               $display("FAIL kat_load_drop[%0d]: done=%b odat=%h expected done=0 odat=%h", i, done, odat, last_result);
            end
         end
         wait_done(lat);
         e = exp_q.pop_front();
         $display("[TB] kat %0d p=%h k=%h -> odat=%h latency=%0d", i, pv[i], kv[i], odat, lat);
         tests_run++;
         if (lat != 32) begin
            tests_failed++;
            $display("FAIL kat_latency[%0d]: got %0d expected 32", i, lat);
         end
         tests_run++;
         if (odat !== e) begin
            tests_failed++;
            $display("FAIL kat_odat[%0d]: got %h expected %h", i, odat, e);
         end
         last_result = e;
      end
   endtask

   task automatic test_hold();
      int bad = 0;
      for (int c = 0; c < 120; c++) begin
         @(negedge clk);
         idat = rand64();
         key  = rand80();
         if (done !== 1'b1 || odat !== last_result) bad++;
      end
      $display("[TB] hold 120 cycles with toggling inputs, deviations=%0d", bad);
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL hold_stable: got %0d unstable cycles expected 0", bad);
      end
   endtask

   task automatic test_abort_reload();
      logic [63:0] pa, pb, e;
      logic [79:0] ka, kb;
      int lat;
      pa = rand64(); ka = rand80();
      pb = rand64(); kb = rand80();
      drive_load(pa, ka, ref_encrypt(pa, ka));
      repeat (9) @(negedge clk);
      drive_load(pb, kb, ref_encrypt(pb, kb));
      wait_done(lat);
      e = exp_q.pop_front();
      $display("[TB] abort/reload p=%h k=%h -> odat=%h latency=%0d", pb, kb, odat, lat);
      tests_run++;
      if (lat != 32) begin
         tests_failed++;
         $display("FAIL reload_latency: got %0d expected 32", lat);
      end
      tests_run++;
      if (odat !== e) begin
         tests_failed++;
         $display("FAIL reload_odat: got %h expected %h", odat, e);
      end
      last_result = e;
   endtask

   task automatic test_load_at_done_edge();
      logic [63:0] pa, pb, e, prev;
      logic [79:0] ka, kb;
      int lat;
      prev = last_result;
      pa = rand64(); ka = rand80();
      pb = rand64(); kb = rand80();
      drive_load(pa, ka, ref_encrypt(pa, ka));
      repeat (30) @(negedge clk);
      // This load lands on the edge where A would have completed.
      drive_load(pb, kb, ref_encrypt(pb, kb));
      tests_run++;
      if (done !== 1'b0 || odat !== prev) begin
         tests_failed++;
         $display("FAIL edge_load_priority: done=%b odat=%h expected done=0 odat=%h", done, odat, prev);
      end
      wait_done(lat);
      e = exp_q.pop_front();
      $display("[TB] load-at-done-edge p=%h k=%h -> odat=%h latency=%0d", pb, kb, odat, lat);
      tests_run++;
      if (lat != 32 || odat !== e) begin
         tests_failed++;
         $display("FAIL edge_load_result: latency=%0d odat=%h expected latency=32 odat=%h", lat, odat, e);
      end
      last_result = e;
   endtask

   task automatic test_reset_mid_op();
      logic [63:0] pa;
      logic [79:0] ka;
      int rises = 0;
      pa = rand64(); ka = rand80();
      drive_load(pa, ka, ref_encrypt(pa, ka));
      repeat (14) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      tests_run++;
      if (odat !== 64'h0 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL midop_reset: odat=%h done=%b expected odat=0 done=0", odat, done);
      end
      repeat (40) begin
         @(negedge clk);
         if (done) rises++;
      end
      $display("[TB] reset mid-operation, done-high cycles afterwards=%0d", rises);
      tests_run++;
      if (rises != 0) begin
         tests_failed++;
         $display("FAIL midop_no_done: got %0d done cycles expected 0", rises);
      end
   endtask

   task automatic test_reset_and_load();
      logic [63:0] pa;
      logic [79:0] ka;
      int lat;
      int rises = 0;
      pa = rand64(); ka = rand80();
      drive_load(pa, ka, ref_encrypt(pa, ka));
      wait_done(lat);
      @(negedge clk);
      reset = 1'b1;
      load  = 1'b1;
      idat  = rand64();
      key   = rand80();
      @(negedge clk);
      reset = 1'b0;
      load  = 1'b0;
      exp_q.delete();
      tests_run++;
      if (odat !== 64'h0 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_load_clear: odat=%h done=%b expected odat=0 done=0", odat, done);
      end
      repeat (40) begin
         @(negedge clk);
         if (done) rises++;
      end
      $display("[TB] reset with load, done-high cycles afterwards=%0d", rises);
      tests_run++;
      if (rises != 0) begin
         tests_failed++;
         $display("FAIL reset_beats_load: got %0d done cycles expected 0", rises);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] p, e;
      logic [79:0] k;
      int lat;
      for (int i = 0; i <= 25; i++) begin
         p = rand64();
         k = rand80();
         drive_load(p, k, ref_encrypt(p, k));
         if (i > 0) begin
            tests_run++;
            if (done !== 1'b0 || odat !== last_result) begin
               tests_failed++;
               $display("FAIL b2b_drop[%0d]: done=%b odat=%h expected done=0 odat=%h", i, done, odat, last_result);
            end
         end
         wait_done(lat);
         if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL b2b_scoreboard[%0d]: got empty queue expected one entry", i);
         end else begin
            e = exp_q.pop_front();
            $display("[TB] b2b %0d p=%h k=%h -> odat=%h latency=%0d", i, p, k, odat, lat);
            tests_run++;
            if (lat != 32 || odat !== e) begin
               tests_failed++;
               $display("FAIL b2b_result[%0d]: latency=%0d odat=%h expected latency=32 odat=%h", i, lat, odat, e);
            end
            last_result = e;
         end
      end
   endtask

   initial begin
      reset = 1'b0;
      load  = 1'b0;
      idat  = '0;
      key   = '0;
      last_result = '0;
      test_reset();
      test_known_vectors();
      test_hold();
      test_abort_reload();
      test_load_at_done_edge();
      test_reset_mid_op();
      test_reset_and_load();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/present_encrypt_core.md
PRESENT_ENCRYPT_CORE -- requirements
Module: present_encrypt_core

Interface
REQ-001 Parameters: none; the block is fixed at 64-bit block, 80-bit key, 31 rounds (PRESENT-80).
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 reset  input  1  reset; synchronous and active-high.
REQ-004 load  input  1  start strobe; samples idat and key on the rising clk edge where load=1.
REQ-005 idat  input  64  plaintext, bit 63 = MSB.
REQ-006 key  input  80  cipher key, bit 79 = MSB.
REQ-007 odat  output  64  ciphertext, registered.
REQ-008 done  output  1  registered; high while odat holds a valid ciphertext.

Function
REQ-009 The block SHALL implement PRESENT-80 encryption exactly as specified by Bogdanov et al. (CHES 2007): 31 rounds of addRoundKey, sBoxLayer and pLayer, then a final addRoundKey with K32.
REQ-010 The round key K_i SHALL be key register bits [79:16].
REQ-011 Key update per round i (1..31) SHALL be: rotate the 80-bit register left by 61; pass bits [79:76] through the S-box; XOR bits [19:15] with the 5-bit round counter i.
REQ-012 The S-box SHALL be 0..F -> C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2 (hex).
REQ-013 pLayer SHALL move state bit j to position (16*j) mod 63 for j = 0..62; bit 63 stays at 63.
REQ-014 Datapath SHALL be iterative: one round per clk cycle, with a single 16-instance S-box layer for the state and one S-box for the key.
REQ-015 Load edge E0: state <= idat, key register <= key, round counter <= 1, busy <= 1, done <= 0.
REQ-016 At edges E1..E31, while busy: state <= pLayer(sBox(state ^ K_i)); key register is updated per REQ-011; counter increments.
REQ-017 At edge E32: odat <= state ^ K32, done <= 1, busy <= 0; latency is 32 cycles from load edge to done high.
REQ-018 done and odat SHALL hold until the next load or reset, regardless of idat and key changes.
REQ-019 A load while busy SHALL abort the current operation and restart per REQ-015; the partial result is discarded.
REQ-020 A load in the same cycle that done would rise SHALL take priority: done stays 0 and the operation restarts.
REQ-021 A load while done=1 SHALL drop done to 0 on the load edge; odat keeps its old value until the new result is written.
REQ-022 The round counter SHALL be 5 bits and SHALL never wrap during an operation (values 1..31 only).

Reset
REQ-023 On reset=1 at a rising clk edge: odat=0, done=0, busy=0, counter=0; state and key registers are cleared to 0.
REQ-024 Reset SHALL take priority over load in the same cycle.
REQ-025 Reset asserted mid-operation SHALL abort the operation; done stays 0 until a later load completes.

Structure
REQ-026 A shared package present_pkg SHALL hold the S-box table/function, the pLayer function, and the constants BLOCK_W=64, KEY_W=80, ROUNDS=31.
REQ-027 One sub-module, present_sbox (4-bit in, 4-bit out, combinational), SHALL be instantiated 17 times (16 for the state, 1 for the key).
REQ-028 Target size is 120-400 lines of RTL; no memories and no multicycle paths.

Verification
REQ-029 Load P=0000000000000000, K=0 -> done rises exactly 32 cycles later with odat=5579C1387B228445.
REQ-030 Load P=FFFFFFFFFFFFFFFF, K=0 -> odat=A112FFC72F68417B; load P=0, K=FFFFFFFFFFFFFFFFFFFF -> odat=E72C46C0F5945049.
REQ-031 Load P=FFFFFFFFFFFFFFFF, K=FFFFFFFFFFFFFFFFFFFF -> odat=3333DCD3213210D2; done and odat stay stable for 100 or more cycles while idat and key toggle randomly.
REQ-032 Load vector A, re-load vector B at cycle 10 -> done rises 32 cycles after the second load with B's ciphertext only; no done pulse for A.
REQ-033 Assert reset at cycle 15 of an operation -> odat=0 and done=0 on the next edge; done never rises until a new load; reset and load together -> reset wins.
REQ-034 Back-to-back loads with random vectors, 25 pairs, each load issued when done=1 -> results match a software reference model; done drops on each load edge.
